// File: rtl/uart_fifo_scheduler_if.sv
// Signal bundle between uart_fifo_scheduler and its two producers, the shared byte FIFO and uart_tx.
// master = scheduler side, slave = surrounding UART top level.
interface uart_fifo_scheduler_if #(
    parameter int unsigned DATA_W = 8
);
    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              fifo_push;
    logic [DATA_W-1:0] fifo_w_data;
    logic              fifo_full;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_r_data;
    logic              fifo_empty;
    logic              tx_en;
    logic              tx_busy;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;

    modport master (
        input  req0_valid, req0_data, req1_valid, req1_data,
        input  fifo_full, fifo_r_data, fifo_empty, tx_en, tx_busy,
        output req0_ready, req1_ready, fifo_push, fifo_w_data, fifo_pop,
        output tx_start, tx_data
    );

    modport slave (
        output req0_valid, req0_data, req1_valid, req1_data,
        output fifo_full, fifo_r_data, fifo_empty, tx_en, tx_busy,
        input  req0_ready, req1_ready, fifo_push, fifo_w_data, fifo_pop,
        input  tx_start, tx_data
    );
endinterface

// File: rtl/uart_fifo_scheduler.sv
// Round-robin push arbiter for two producers into a shared byte FIFO, plus the FIFO->uart_tx drain FSM.
// Define UFS_BURST_LOCK_EN to keep the grant with one requester for up to MAX_BURST consecutive bytes.
module uart_fifo_scheduler #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_fifo_scheduler_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              gnt_vld;
    logic              gnt_idx;
    logic              pop;
    logic              start;
    logic              locked;

`ifdef UFS_BURST_LOCK_EN
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0] burst_q, burst_d, burst_nxt;

    // The burst owner is always the index rr_ptr points away from.
    assign locked = (burst_q != '0) && (rr_ptr_q ? bus.req0_valid : bus.req1_valid);

    always_comb begin
        burst_nxt = locked ? burst_q + CNT_W'(1) : CNT_W'(1);
        burst_d   = burst_q;
        if (gnt_vld) begin
            burst_d = (burst_nxt == CNT_W'(MAX_BURST)) ? '0 : burst_nxt;
        end else if (!bus.fifo_full) begin
            burst_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    assign locked = 1'b0;
`endif

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = 1'b0;
        rr_ptr_d = rr_ptr_q;
        if (!rst && !bus.fifo_full && (bus.req0_valid || bus.req1_valid)) begin
            gnt_vld = 1'b1;
            if (locked) begin
                gnt_idx = ~rr_ptr_q;
            end else if (bus.req0_valid && bus.req1_valid) begin
                gnt_idx = rr_ptr_q;
            end else begin
                gnt_idx = bus.req1_valid;
            end
        end
        if (gnt_vld) begin
            rr_ptr_d = ~gnt_idx;
        end
    end

    assign bus.fifo_push   = gnt_vld;
    assign bus.fifo_w_data = gnt_idx ? bus.req1_data : bus.req0_data;
    assign bus.req0_ready  = gnt_vld && !gnt_idx;
    assign bus.req1_ready  = gnt_vld && gnt_idx;

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        start     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!bus.fifo_empty && bus.tx_en && !bus.tx_busy) begin
                    pop       = 1'b1;
                    tx_data_d = bus.fifo_r_data;
                    state_d   = START;
                end
            end
            START: begin
                start   = 1'b1;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.fifo_pop = pop && !rst;
    assign bus.tx_start = start;
    assign bus.tx_data  = tx_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_data_q <= '0;
            rr_ptr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end
endmodule

// File: tb/tb_uart_fifo_scheduler.sv
// Self-checking bench: behavioural 4-deep FIFO and uart_tx models, scoreboards for push order and transmit order.
module tb_uart_fifo_scheduler;
    localparam int unsigned TX_CYC = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_fifo_scheduler_if #(.DATA_W(8)) bus ();

    uart_fifo_scheduler #(.DATA_W(8), .MAX_BURST(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] src0[$];
    logic [7:0] src1[$];
    logic [7:0] exp_push[$];
    logic [7:0] exp_tx[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FIFO model
    logic [7:0] mem [4];
    logic [1:0] wp = '0;
    logic [1:0] rp = '0;
    logic [2:0] cnt = '0;

    always @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (bus.fifo_push) begin
                mem[wp] <= bus.fifo_w_data;
                wp      <= wp + 2'd1;
            end
            if (bus.fifo_pop) rp <= rp + 2'd1;
            cnt <= cnt + 3'(bus.fifo_push) - 3'(bus.fifo_pop);
        end
    end

    assign bus.fifo_full   = (cnt == 3'd4);
    assign bus.fifo_empty  = (cnt == 3'd0);
    assign bus.fifo_r_data = mem[rp];

    // TX model: busy for TX_CYC cycles starting the edge after tx_start
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (bus.tx_start) busy_cnt <= TX_CYC;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.tx_busy = (busy_cnt != 0);

    // Requester drivers: hold data while valid and not ready
    initial begin
        logic a0, a1;
        bus.req0_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_data  = '0;
        forever begin
            @(negedge clk);
            a0 = bus.req0_valid && bus.req0_ready;
            a1 = bus.req1_valid && bus.req1_ready;
            @(posedge clk);
            #1;
            if (a0) void'(src0.pop_front());
            if (a1) void'(src1.pop_front());
            bus.req0_valid = (src0.size() != 0);
            bus.req0_data  = (src0.size() != 0) ? src0[0] : 8'h00;
            bus.req1_valid = (src1.size() != 0);
            bus.req1_data  = (src1.size() != 0) ? src1[0] : 8'h00;
        end
    end

    // Monitor
    logic last_pop   = 1'b0;
    logic last_start = 1'b0;
    int   pop_cnt    = 0;
    int   start_cnt  = 0;
    int   r1_cnt     = 0;

    always @(negedge clk) begin
        if (bus.fifo_push) begin
            check_eq("push_full", 32'(bus.fifo_full), 0);
            if (exp_push.size() == 0) check_eq("push_unexp", 1, 0);
            else check_eq("push_data", 32'(bus.fifo_w_data), 32'(exp_push.pop_front()));
        end
        if (bus.fifo_pop) begin
            pop_cnt++;
            check_eq("pop_busy", 32'(bus.tx_busy), 0);
            check_eq("pop_empty", 32'(bus.fifo_empty), 0);
            check_eq("pop_txen", 32'(bus.tx_en), 1);
        end
        if (bus.tx_start) begin
            start_cnt++;
            check_eq("start_lat", 32'(last_pop), 1);
            check_eq("start_len", 32'(last_start), 0);
            if (exp_tx.size() == 0) check_eq("tx_unexp", 1, 0);
            else check_eq("tx_data", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
        end
        if (bus.req1_ready) r1_cnt++;
        last_pop   = bus.fifo_pop;
        last_start = bus.tx_start;
    end

    task automatic send(input bit which, input logic [7:0] b);
        if (which) src1.push_back(b);
        else src0.push_back(b);
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_push.push_back(b);
        exp_tx.push_back(b);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((src0.size() != 0 || src1.size() != 0 || exp_tx.size() != 0) && n < 800) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        while (bus.tx_busy && n < 800) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        check_eq(tag, 32'(n < 800), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.tx_en = 1'b1;

        // Reset state with a requester already valid; then single-requester transfer
        send(0, 8'h41); expect_byte(8'h41);
        send(0, 8'h42); expect_byte(8'h42);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready0", 32'(bus.req0_ready), 0);
        check_eq("rst_ready1", 32'(bus.req1_ready), 0);
        check_eq("rst_push", 32'(bus.fifo_push), 0);
        check_eq("rst_pop", 32'(bus.fifo_pop), 0);
        check_eq("rst_start", 32'(bus.tx_start), 0);
        check_eq("rst_txdata", 32'(bus.tx_data), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        r1_cnt = 0;
        wait_drain("single_drain");
        check_eq("single_r1_ready", 32'(r1_cnt), 0);

        // Contention
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(0, 8'hA0 + 8'(i));
            send(1, 8'hB0 + 8'(i));
        end
`ifdef UFS_BURST_LOCK_EN
        for (int i = 0; i < 4; i++) expect_byte(8'hA0 + 8'(i));
        for (int i = 0; i < 4; i++) expect_byte(8'hB0 + 8'(i));
`else
        for (int i = 0; i < 4; i++) begin
            expect_byte(8'hA0 + 8'(i));
            expect_byte(8'hB0 + 8'(i));
        end
`endif
        wait_drain("contend_drain");

        // Full stall
        do_reset();
        bus.tx_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(0, 8'hC0 + 8'(i));
            expect_byte(8'hC0 + 8'(i));
        end
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_eq("stall_full", 32'(bus.fifo_full), 1);
        check_eq("stall_ready0", 32'(bus.req0_ready), 0);
        check_eq("stall_ready1", 32'(bus.req1_ready), 0);
        check_eq("stall_push", 32'(bus.fifo_push), 0);
        check_eq("stall_held", 32'(src0.size()), 1);
        @(posedge clk);
        #1 bus.tx_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 check_eq("stall_accept", 32'(src0.size()), 0);
        wait_drain("stall_drain");

        // tx_en pause
        do_reset();
        bus.tx_en = 1'b0;
        send(0, 8'h55); expect_byte(8'h55);
        pop_cnt   = 0;
        start_cnt = 0;
        repeat (20) @(posedge clk);
        #2;
        check_eq("pause_pops", 32'(pop_cnt), 0);
        check_eq("pause_starts", 32'(start_cnt), 0);
        bus.tx_en = 1'b1;
        wait_drain("pause_drain");
        check_eq("pause_one_start", 32'(start_cnt), 1);

        // Reset mid-frame
        do_reset();
        send(0, 8'h66); expect_byte(8'h66);
        begin
            int n = 0;
            while (!bus.tx_busy && n < 50) begin
                @(posedge clk);
                n++;
            end
            check_eq("midrst_busy_seen", 32'(n < 50), 1);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send(0, 8'h77); expect_byte(8'h77);
        @(negedge clk);
        check_eq("midrst_start", 32'(bus.tx_start), 0);
        check_eq("midrst_txdata", 32'(bus.tx_data), 0);
        check_eq("midrst_pop", 32'(bus.fifo_pop), 0);
        check_eq("midrst_still_busy", 32'(bus.tx_busy), 1);
        wait_drain("midrst_drain");

        // Simultaneous push and pop
        do_reset();
        bus.tx_en = 1'b0;
        send(0, 8'h10); expect_byte(8'h10);
        repeat (4) @(posedge clk);
        #2 send(1, 8'h20);
        expect_byte(8'h20);
        @(posedge clk);
        #1 bus.tx_en = 1'b1;
        @(negedge clk);
        check_eq("simul_pop", 32'(bus.fifo_pop), 1);
        check_eq("simul_push", 32'(bus.fifo_push), 1);
        check_eq("simul_ready1", 32'(bus.req1_ready), 1);
        @(posedge clk);
        #2;
        check_eq("simul_txdata", 32'(bus.tx_data), 32'h10);
        check_eq("simul_head", 32'(bus.fifo_r_data), 32'h20);
        check_eq("simul_nempty", 32'(bus.fifo_empty), 0);
        check_eq("simul_count", 32'(cnt), 1);
        wait_drain("simul_drain");

        check_eq("sb_push_left", 32'(exp_push.size()), 0);
        check_eq("sb_tx_left", 32'(exp_tx.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
